// File: rtl/ctl_axi_lite_initiator.sv
// Single-outstanding command/response to AXI4-Lite master bridge for a partition control port.
// A cycle-count timeout converts a silent partition into a local DECERR response and a sticky hung flag.
module ctl_axi_lite_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  hung,
  input  logic                  clear,
  output logic [ADDR_WIDTH-1:0] CTL_M_AXI_LITE_awaddr,
  output logic [2:0]            CTL_M_AXI_LITE_awprot,
  output logic                  CTL_M_AXI_LITE_awvalid,
  input  logic                  CTL_M_AXI_LITE_awready,
  output logic [31:0]           CTL_M_AXI_LITE_wdata,
  output logic [3:0]            CTL_M_AXI_LITE_wstrb,
  output logic                  CTL_M_AXI_LITE_wvalid,
  input  logic                  CTL_M_AXI_LITE_wready,
  input  logic [1:0]            CTL_M_AXI_LITE_bresp,
  input  logic                  CTL_M_AXI_LITE_bvalid,
  output logic                  CTL_M_AXI_LITE_bready,
  output logic [ADDR_WIDTH-1:0] CTL_M_AXI_LITE_araddr,
  output logic [2:0]            CTL_M_AXI_LITE_arprot,
  output logic                  CTL_M_AXI_LITE_arvalid,
  input  logic                  CTL_M_AXI_LITE_arready,
  input  logic [31:0]           CTL_M_AXI_LITE_rdata,
  input  logic [1:0]            CTL_M_AXI_LITE_rresp,
  input  logic                  CTL_M_AXI_LITE_rvalid,
  output logic                  CTL_M_AXI_LITE_rready
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [1:0]    DECERR   = 2'b11;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  take_to;
  logic                  aw_left, w_left;
  logic                  cmd_ready_nxt, rsp_valid_nxt, rsp_timeout_nxt;
  logic [31:0]           rsp_rdata_nxt;
  logic [1:0]            rsp_resp_nxt;
  logic [ADDR_WIDTH-1:0] awaddr_nxt, araddr_nxt;
  logic [31:0]           wdata_nxt;
  logic [3:0]            wstrb_nxt;
  logic                  awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;

  assign CTL_M_AXI_LITE_awprot = 3'b000;
  assign CTL_M_AXI_LITE_arprot = 3'b000;

  // Each write channel stays valid until its own handshake.
  assign aw_left = CTL_M_AXI_LITE_awvalid & ~CTL_M_AXI_LITE_awready;
  assign w_left  = CTL_M_AXI_LITE_wvalid  & ~CTL_M_AXI_LITE_wready;

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    take_to         = 1'b0;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_resp_nxt    = rsp_resp;
    rsp_timeout_nxt = rsp_timeout;
    awaddr_nxt      = CTL_M_AXI_LITE_awaddr;
    araddr_nxt      = CTL_M_AXI_LITE_araddr;
    wdata_nxt       = CTL_M_AXI_LITE_wdata;
    wstrb_nxt       = CTL_M_AXI_LITE_wstrb;
    awvalid_nxt     = CTL_M_AXI_LITE_awvalid;
    wvalid_nxt      = CTL_M_AXI_LITE_wvalid;
    bready_nxt      = CTL_M_AXI_LITE_bready;
    arvalid_nxt     = CTL_M_AXI_LITE_arvalid;
    rready_nxt      = CTL_M_AXI_LITE_rready;

    // Saturating at TIMEOUT_CYCLES keeps the counter from wrapping if a
    // handshake lands exactly on the expiry cycle.
    if (state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP})
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cnt_nxt = '0;
          if (hung) begin
            state_nxt       = RSP;
            rsp_valid_nxt   = 1'b1;
            rsp_rdata_nxt   = '0;
            rsp_resp_nxt    = DECERR;
            rsp_timeout_nxt = 1'b1;
          end else if (cmd_write) begin
            state_nxt   = WR_REQ;
            awaddr_nxt  = cmd_addr;
            wdata_nxt   = cmd_wdata;
            wstrb_nxt   = cmd_wstrb;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
          end else begin
            state_nxt   = RD_REQ;
            araddr_nxt  = cmd_addr;
            arvalid_nxt = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (!aw_left && !w_left) begin
          state_nxt   = WR_RESP;
          awvalid_nxt = 1'b0;
          wvalid_nxt  = 1'b0;
          bready_nxt  = 1'b1;
        end else if (cnt >= CNT_LAST) begin
          take_to = 1'b1;
        end else begin
          awvalid_nxt = aw_left;
          wvalid_nxt  = w_left;
        end
      end
      WR_RESP: begin
        if (CTL_M_AXI_LITE_bvalid) begin
          state_nxt       = RSP;
          bready_nxt      = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = '0;
          rsp_resp_nxt    = CTL_M_AXI_LITE_bresp;
          rsp_timeout_nxt = 1'b0;
        end else if (cnt >= CNT_LAST) begin
          take_to = 1'b1;
        end
      end
      RD_REQ: begin
        if (CTL_M_AXI_LITE_arready) begin
          state_nxt   = RD_RESP;
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
        end else if (cnt >= CNT_LAST) begin
          take_to = 1'b1;
        end
      end
      RD_RESP: begin
        if (CTL_M_AXI_LITE_rvalid) begin
          state_nxt       = RSP;
          rready_nxt      = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_rdata_nxt   = CTL_M_AXI_LITE_rdata;
          rsp_resp_nxt    = CTL_M_AXI_LITE_rresp;
          rsp_timeout_nxt = 1'b0;
        end else if (cnt >= CNT_LAST) begin
          take_to = 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abandon the transaction: unhandshaken valids are dropped on purpose so
    // the partition is decoupled before it is reloaded.
    if (take_to) begin
      state_nxt       = RSP;
      awvalid_nxt     = 1'b0;
      wvalid_nxt      = 1'b0;
      bready_nxt      = 1'b0;
      arvalid_nxt     = 1'b0;
      rready_nxt      = 1'b0;
      rsp_valid_nxt   = 1'b1;
      rsp_rdata_nxt   = '0;
      rsp_resp_nxt    = DECERR;
      rsp_timeout_nxt = 1'b1;
    end

    cmd_ready_nxt = (state_nxt == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      cnt                    <= '0;
      cmd_ready              <= 1'b0;
      rsp_valid              <= 1'b0;
      rsp_rdata              <= '0;
      rsp_resp               <= '0;
      rsp_timeout            <= 1'b0;
      CTL_M_AXI_LITE_awaddr  <= '0;
      CTL_M_AXI_LITE_araddr  <= '0;
      CTL_M_AXI_LITE_wdata   <= '0;
      CTL_M_AXI_LITE_wstrb   <= '0;
      CTL_M_AXI_LITE_awvalid <= 1'b0;
      CTL_M_AXI_LITE_wvalid  <= 1'b0;
      CTL_M_AXI_LITE_bready  <= 1'b0;
      CTL_M_AXI_LITE_arvalid <= 1'b0;
      CTL_M_AXI_LITE_rready  <= 1'b0;
    end else begin
      state                  <= state_nxt;
      cnt                    <= cnt_nxt;
      cmd_ready              <= cmd_ready_nxt;
      rsp_valid              <= rsp_valid_nxt;
      rsp_rdata              <= rsp_rdata_nxt;
      rsp_resp               <= rsp_resp_nxt;
      rsp_timeout            <= rsp_timeout_nxt;
      CTL_M_AXI_LITE_awaddr  <= awaddr_nxt;
      CTL_M_AXI_LITE_araddr  <= araddr_nxt;
      CTL_M_AXI_LITE_wdata   <= wdata_nxt;
      CTL_M_AXI_LITE_wstrb   <= wstrb_nxt;
      CTL_M_AXI_LITE_awvalid <= awvalid_nxt;
      CTL_M_AXI_LITE_wvalid  <= wvalid_nxt;
      CTL_M_AXI_LITE_bready  <= bready_nxt;
      CTL_M_AXI_LITE_arvalid <= arvalid_nxt;
      CTL_M_AXI_LITE_rready  <= rready_nxt;
    end
  end

  // A timeout outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          hung <= 1'b0;
    else if (take_to) hung <= 1'b1;
    else if (clear)   hung <= 1'b0;
  end

endmodule
